// File: rtl/mdu_issue_if.sv
// -----------------------------------------------------------------------------
// mdu_issue_if : request/response handshake bundle between decode (master)
//                and the MDU issue controller (slave).
//
//   req_valid / req_ready   request handshake (decode -> controller)
//   req_op  [3:0]           MD op code
//   req_rs, req_rt          operands
//   stall                   req_valid & ~req_ready, back to the pipeline
//   flush                   cancel pending response / incoming request
//   rsp_valid / rsp_ready   mfhi/mflo result handshake (controller -> consumer)
//   rsp_data                result data
// -----------------------------------------------------------------------------
interface mdu_issue_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_rs;
    logic [WIDTH-1:0] req_rt;
    logic             req_ready;
    logic             stall;
    logic             flush;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ready;

    modport master (
        output req_valid, req_op, req_rs, req_rt, flush, rsp_ready,
        input  req_ready, stall, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, flush, rsp_ready,
        output req_ready, stall, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mdu_issue.sv
// -----------------------------------------------------------------------------
// mdu_issue : E-stage initiator for the multiply/divide unit.
//
// Accepts one MD instruction at a time, drives MDUOp/R1/R2 for exactly one
// cycle, tracks the MDU Busy line and returns mfhi/mflo results over a
// valid/ready response channel.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   bus (slave)       request / response handshake, stall, flush
//   mdu_op, mdu_r1,   operation and operands to the MDU (op is 0 when idle)
//   mdu_r2
//   mdu_busy          Busy from the MDU
//   mdu_hi, mdu_lo    HI/LO from the MDU
//   err               one-cycle pulse: illegal op, watchdog abort, or
//                     (when MDU_DIV0_TRAP_EN is defined) divide by zero
//
// Build option: MDU_DIV0_TRAP_EN -- when defined, div/divu with rt == 0 is
// dropped in ISSUE (mdu_op stays 0) and err pulses; HI/LO are untouched.
// -----------------------------------------------------------------------------
module mdu_issue #(
    parameter int WIDTH    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    mdu_issue_if.slave       bus,
    output logic [3:0]       mdu_op,
    output logic [WIDTH-1:0] mdu_r1,
    output logic [WIDTH-1:0] mdu_r2,
    input  logic             mdu_busy,
    input  logic [WIDTH-1:0] mdu_hi,
    input  logic [WIDTH-1:0] mdu_lo,
    output logic             err
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_n;
    logic [3:0]       cap_op;
    logic [WIDTH-1:0] cap_rs, cap_rt;
    logic [CW-1:0]    wcnt;
    logic [WIDTH-1:0] rsp_data_q;
    logic             err_q, err_n;
    logic             ready_c;
    logic             accept;
    logic             div0_trap;
    logic             rsp_valid_c;

    function automatic logic is_legal(input logic [3:0] op);
        return (op != 4'd0) && (op <= 4'd8);
    endfunction

    // mult, multu, div, divu: the MDU goes busy and must be waited on
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    // mfhi, mflo: answered directly from HI/LO, no MDU operation
    function automatic logic is_mf(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd6);
    endfunction

    // Held low while reset is asserted so nothing is accepted during reset.
    assign ready_c = (state == IDLE) & ~mdu_busy & ~bus.flush & ~reset;
    assign accept  = ready_c & bus.req_valid;

`ifdef MDU_DIV0_TRAP_EN
    assign div0_trap = ((cap_op == 4'd3) || (cap_op == 4'd4)) && (cap_rt == '0);
`else
    assign div0_trap = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and err decision
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_legal(bus.req_op))  err_n   = 1'b1;
                    else if (is_mf(bus.req_op)) state_n = RESP;
                    else                        state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (div0_trap) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end else if (is_muldiv(cap_op)) begin
                    state_n = WAIT;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                // wcnt counts completed WAIT cycles; abort after WAIT_MAX of them
                if (!mdu_busy) begin
                    state_n = IDLE;
                end else if (wcnt == CW'(WAIT_MAX - 1)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            RESP: begin
                if (bus.flush || bus.rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        mdu_op      = 4'd0;
        mdu_r1      = '0;
        mdu_r2      = '0;
        rsp_valid_c = 1'b0;
        case (state)
            ISSUE: begin
                if (!div0_trap) begin
                    mdu_op = cap_op;
                    mdu_r1 = cap_rs;
                    mdu_r2 = cap_rt;
                end
            end
            RESP:    rsp_valid_c = 1'b1;
            default: ;
        endcase
    end

    // Captured request, wait counter, response data and err pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_op     <= 4'd0;
            cap_rs     <= '0;
            cap_rt     <= '0;
            wcnt       <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_n;
            if (accept) begin
                cap_op <= bus.req_op;
                cap_rs <= bus.req_rs;
                cap_rt <= bus.req_rt;
                if (bus.req_op == 4'd5)      rsp_data_q <= mdu_hi;
                else if (bus.req_op == 4'd6) rsp_data_q <= mdu_lo;
            end
            if (state == ISSUE)     wcnt <= '0;
            else if (state == WAIT) wcnt <= wcnt + 1'b1;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.stall     = bus.req_valid & ~ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_data  = rsp_data_q;
    assign err           = err_q;

endmodule
